// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop, LSB first,
// with a start/busy/done handshake and signed-overflow reporting.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             carry;
  logic [CW-1:0]    count;
  logic             sum;
  logic             carry_out;

  assign sum       = sh_a[0] ^ sh_b[0] ^ carry;
  assign carry_out = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));

  // NOTE: every register here is written with <= so all updates use pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sh_a     <= '0;
      sh_b     <= '0;
      carry    <= 1'b0;
      count    <= '0;
      out      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + 1: the +1 enters through the carry flop.
            sh_a  <= data_a;
            sh_b  <= sub ? ~data_b : data_b;
            carry <= sub;
            count <= '0;
            out   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          out   <= {sum, out[WIDTH-1:1]};
          carry <= carry_out;
          count <= count + CW'(1);
          if (count == LAST_BIT) begin
            // carry here is the carry into the MSB; xor with its carry out flags signed overflow.
            cout     <= carry_out;
            overflow <= carry ^ carry_out;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed cases, randomized operations
// against an arithmetic reference model, protocol and reset checks, WIDTH=16 instance.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, sub;
  logic [7:0]  data_a, data_b, out;
  logic        busy, done, cout, overflow;

  logic        start_w, sub_w;
  logic [15:0] data_a_w, data_b_w, out_w;
  logic        busy_w, done_w, cout_w, overflow_w;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .sub(sub),
    .data_a(data_a), .data_b(data_b),
    .busy(busy), .done(done), .out(out), .cout(cout), .overflow(overflow)
  );

  serial_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start_w), .sub(sub_w),
    .data_a(data_a_w), .data_b(data_b_w),
    .busy(busy_w), .done(done_w), .out(out_w), .cout(cout_w), .overflow(overflow_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {overflow, cout, result} from unsigned/signed integer arithmetic.
  function automatic logic [33:0] ref_model(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic s);
    longint modulus, ua, ub, sa, sb, r, sr;
    logic   c, v;
    logic [31:0] res;
    modulus = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[w-1] ? ua - modulus : ua;
    sb = b[w-1] ? ub - modulus : ub;
    if (s) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      c  = (r >= modulus);
      sr = sa + sb;
    end
    if (r < 0) r = r + modulus;
    if (r >= modulus) r = r - modulus;
    res = 32'(r);
    v = (sr < -(modulus / 2)) || (sr >= modulus / 2);
    return {v, c, res};
  endfunction

  // One 8-bit operation; operands are scrambled while it runs.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic [7:0] exp_out,
                      input logic exp_c, input logic exp_v);
    int n, busy_cycles;
    data_a = a;
    data_b = b;
    sub    = s;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    busy_cycles = 0;
    while (!done && n < 40) begin
      if (busy) busy_cycles++;
      data_a = 8'($urandom);
      data_b = 8'($urandom);
      sub    = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n + 1, 9);
    check({tag, "_busy_cycles"}, busy_cycles, 8);
    check({tag, "_busy_in_done"}, busy, 1'b0);
    check({tag, "_out"}, out, exp_out);
    check({tag, "_cout"}, cout, exp_c);
    check({tag, "_ovf"}, overflow, exp_v);
  endtask

  initial begin
    int n, pulses;
    logic [7:0]  ra, rb;
    logic        rs;
    logic [33:0] m;

    reset = 1'b1; start = 1'b0; sub = 1'b0; data_a = '0; data_b = '0;
    start_w = 1'b0; sub_w = 1'b0; data_a_w = '0; data_b_w = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out", out, 8'h00);
    check("rst_cout_ovf", {cout, overflow}, 2'b00);
    reset = 1'b0;

    // Directed cases
    run8("add_100_27", 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0);
    run8("add_200_100", 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0);
    run8("add_100_50", 8'd100, 8'd50, 1'b0, 8'h96, 1'b0, 1'b1);
    run8("sub_5_9", 8'd5, 8'd9, 1'b1, 8'hFC, 1'b0, 1'b0);
    run8("sub_9_5", 8'd9, 8'd5, 1'b1, 8'd4, 1'b1, 1'b0);
    run8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Held in IDLE after the last op while inputs toggle
    start = 1'b0;
    repeat (3) begin
      data_a = 8'($urandom); data_b = 8'($urandom);
      @(posedge clk); #1;
    end
    check("idle_hold", {out, cout, overflow}, {8'h7F, 1'b1, 1'b1});

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      m = ref_model(8, {24'd0, ra}, {24'd0, rb}, rs);
      run8($sformatf("rnd%0d", i), ra, rb, rs, m[7:0], m[32], m[33]);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // start held high through RUN is ignored; DONE accepts it back-to-back
    @(posedge clk); #1;
    data_a = 8'd1; data_b = 8'd1; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_latency", n + 1, 9);
    check("hold_out", out, 8'd2);
    @(posedge clk); #1;
    start = 1'b0; data_a = 8'($urandom); data_b = 8'($urandom); sub = 1'b1;
    check("b2b_busy", busy, 1'b1);
    n = 1;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_gap", n, 9);
    check("b2b_out", {out, cout, overflow}, {8'd2, 1'b0, 1'b0});

    // Load a result with cout/overflow set, then abort a run with reset
    run8("pre_reset", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    data_a = 8'd55; data_b = 8'd66; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_outs", {busy, done, out, cout, overflow}, 12'h000);
    reset = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("abort_no_done", pulses, 0);

    // WIDTH=16 instance
    data_a_w = 16'hFFFF; data_b_w = 16'h0001; sub_w = 1'b0; start_w = 1'b1;
    @(posedge clk); #1;
    start_w = 1'b0;
    n = 0;
    while (!done_w && n < 60) begin
      data_a_w = 16'($urandom); data_b_w = 16'($urandom);
      @(posedge clk); #1;
      n++;
    end
    check("w16_latency", n + 1, 17);
    check("w16_result", {out_w, cout_w, overflow_w}, {16'h0000, 1'b1, 1'b0});
    for (int i = 0; i < 12; i++) begin
      data_a_w = 16'($urandom); data_b_w = 16'($urandom); sub_w = 1'($urandom);
      @(posedge clk); #1;
      check($sformatf("w16_hold%0d", i), {busy_w, done_w, out_w, cout_w, overflow_w},
            {1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    end

    // A few random 16-bit ops
    for (int i = 0; i < 6; i++) begin
      logic [15:0] a16, b16;
      logic        s16;
      logic [33:0] m16;
      a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
      m16 = ref_model(16, {16'd0, a16}, {16'd0, b16}, s16);
      data_a_w = a16; data_b_w = b16; sub_w = s16; start_w = 1'b1;
      @(posedge clk); #1;
      start_w = 1'b0;
      n = 0;
      while (!done_w && n < 60) begin
        @(posedge clk); #1;
        n++;
      end
      check($sformatf("w16_rnd%0d", i), {out_w, cout_w, overflow_w},
            {m16[15:0], m16[32], m16[33]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor for the arithmetic lab datapath. It adds or subtracts two `WIDTH`-bit operands one bit per clock, LSB first, through a single full-adder slice and a carry flip-flop. It adds a start/busy/done handshake, a subtract mode, and signed-overflow reporting. Results are held stable after completion until the next operation is accepted.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Legal values are `WIDTH >= 2`.
- `clk` input, 1 bit: the single clock. All state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `start` input, 1 bit: request a new operation. Sampled only in `IDLE` or `DONE`.
- `sub` input, 1 bit: operation select, sampled with `start`. 0 computes A+B; 1 computes A−B.
- `data_a` input, `WIDTH` bits: operand A, sampled with `start`.
- `data_b` input, `WIDTH` bits: operand B, sampled with `start`.
- `busy` output, 1 bit: high while bits are being processed.
- `done` output, 1 bit: one-cycle pulse when the result is complete.
- `out` output, `WIDTH` bits: the result, A±B modulo 2^WIDTH.
- `cout` output, 1 bit: final carry out of the MSB. In subtract mode, 1 means no borrow.
- `overflow` output, 1 bit: two's-complement signed overflow, computed as carry-into-MSB XOR carry-out-of-MSB.

## Operation
- There are three states: `IDLE`, `RUN`, `DONE`.
- **Accepting an operation (`IDLE` or `DONE` with `start`=1):**
  - Load shift register A with `data_a`.
  - Load shift register B with `data_b`, bitwise inverted if `sub`=1.
  - Load the carry register with `sub`, giving the +1 for two's-complement subtraction.
  - Clear the bit counter and clear `out`.
  - Go to `RUN`.
- **`RUN`, each cycle:**
  - Full-adder inputs are A[0], B[0] and carry.
  - Shift A and B right by one.
  - Shift `out` right by one, with the sum bit entering `out[WIDTH-1]`.
  - Store the adder's carry out in the carry register.
  - Increment the counter. When processing the bit at count = WIDTH−1, also capture the carry into that bit for overflow.
  - After the WIDTH-th bit, go to `DONE`.
- **`DONE` (exactly one cycle):**
  - `done`=1.
  - `out`, `cout` and `overflow` are final.
  - With `start`=0, go to `IDLE`. With `start`=1, accept the new operation (back-to-back).
- **`IDLE`:** `out`, `cout` and `overflow` hold the last result.
- **`start` during `RUN`:** ignored. The operands and `sub` of the operation in flight are unaffected.
- **Operands after acceptance:** `data_a`, `data_b` and `sub` may change freely.
- **During `RUN`:** `out` holds partial bits and is not valid. `cout` and `overflow` hold their previous values until the `DONE` edge, when they are updated.
- **Counter width:** $clog2(WIDTH+1) bits. It never wraps within an operation.

## Timing
- **Reset values:** state `IDLE`; `busy`, `done`, `out`, `cout` and `overflow` are all 0; counter and carry are 0.
- **Reset priority:** reset has priority over `start`.
- **Reset mid-`RUN` or in `DONE`:**
  - Aborts the operation.
  - No `done` pulse is produced.
  - All outputs return to their reset values on that edge.
- **Latency:** with `start` sampled at edge E0:
  - `busy`=1 from after E0 through edge E(WIDTH).
  - `done`=1 and `busy`=0 in the cycle after E(WIDTH), i.e. WIDTH+1 cycles after E0.
- **Throughput:** back-to-back operations give one result every WIDTH+1 cycles.
- **Output driving:** `busy` and `done` are registered, or decoded directly from state. No combinational path from inputs to outputs.

## Test plan
- **Add, WIDTH=8, `sub`=0, A=100, B=27:**
  - `done` exactly 9 cycles after the start edge.
  - `out`=127, `cout`=0, `overflow`=0.
  - `busy` high for 8 cycles.
- **Add, A=200, B=100:** `out`=44, `cout`=1, `overflow`=0.
- **Add, A=100, B=50:** `out`=150 (0x96), `cout`=0, `overflow`=1.
- **Subtract, `sub`=1:**
  - 5−9: `out`=0xFC, `cout`=0, `overflow`=0.
  - 9−5: `out`=4, `cout`=1.
  - 0x80−0x01: `out`=0x7F, `cout`=1, `overflow`=1.
- **Protocol:**
  - `start` with A=1, B=1 held high through `RUN` is ignored until `DONE`.
  - In `DONE` it immediately starts a second operation; `done` pulses twice, 9 cycles apart.
  - Reset asserted at the 4th `RUN` cycle: no `done`; all outputs 0 the next cycle.
- **WIDTH=16 instance, A=0xFFFF, B=0x0001 add:**
  - `out`=0, `cout`=1, `overflow`=0.
  - `done` 17 cycles after start.
  - `out` then held in `IDLE` for 10+ cycles with `data_a`/`data_b` toggling.
